// File: rtl/ad7124_pkg.sv
// Shared constants, result field widths and sequencer state encoding for the AD7124 scan path.
// Pure declarations: no latency, no flow control.
package ad7124_pkg;

  localparam logic [7:0] CMD_READ_DATA = 8'h42;
  localparam logic [5:0] REG_STATUS    = 6'h00;

  localparam int DATA_W   = 24;
  localparam int STATUS_W = 8;
  localparam int RESULT_W = 32;
  localparam int TS_W     = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_WAIT_RDY,
    ST_CMD,
    ST_READ,
    ST_CS_HOLD,
    ST_OUTPUT,
    ST_NEXT,
    ST_DONE
  } state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [4:0] first_set(input logic [31:0] m);
    first_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) first_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/ad7124_spi_shift.sv
// Mode-3 SPI shifter, MSB first, SCLK half-period CLK_DIV clocks; MISO sampled on the last clock of each high half.
// done_o pulses one cycle after the final high half; start_i is honoured only while idle.
module ad7124_spi_shift #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [5:0]          nbits_i,
  input  logic [MAX_BITS-1:0] tx_dat_i,
  input  logic                miso_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [MAX_BITS-1:0] rx_dat_o,
  output logic                sclk_o,
  output logic                mosi_o
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic [DW-1:0]       div_q, div_d;
  logic [5:0]          bits_q, bits_d;
  logic [MAX_BITS-1:0] sh_q, sh_d;
  logic [MAX_BITS-1:0] rx_q, rx_d;

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    div_d  = div_q;
    bits_d = bits_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = tx_dat_i[MAX_BITS-1];
        sh_d   = tx_dat_i << 1;
        bits_d = nbits_i - 6'd1;
        div_d  = '0;
        rx_d   = '0;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        rx_d = {rx_q[MAX_BITS-2:0], miso_i};
        if (bits_q == 6'd0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          mosi_d = sh_q[MAX_BITS-1];
          sh_d   = sh_q << 1;
          bits_d = bits_q - 6'd1;
        end
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b1;
      mosi_q <= 1'b1;
      div_q  <= '0;
      bits_q <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      div_q  <= div_d;
      bits_q <= bits_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign rx_dat_o = rx_q;
  assign sclk_o   = sclk_q;
  assign mosi_o   = mosi_q;

endmodule

// File: rtl/ad7124_scan_seq.sv
// AD7124 scan sequencer: per start, walks enabled chip selects, waits for RDY, reads DATA and timestamps it.
// One result per channel on m_valid/m_ready; the scan stalls with all CS high while m_ready is low.
module ad7124_scan_seq
  import ad7124_pkg::*;
#(
  parameter int NUM_CS         = 9,
  parameter int CLK_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int DATA_STATUS    = 1,
  localparam int CW            = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                aclk_i,
  input  logic                areset_i,
  input  logic                measure_start_i,
  output logic                measure_ready_o,
  output logic                measure_done_o,
  input  logic [NUM_CS-1:0]   ch_enable_i,
  input  logic [TS_W-1:0]     rtc_sec_i,
  input  logic [TS_W-1:0]     rtc_nsec_i,
  output logic                spi_sclk_o,
  output logic [NUM_CS-1:0]   spi_csn_o,
  output logic                spi_mosi_o,
  input  logic                spi_miso_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [CW-1:0]       m_chan_o,
  output logic [RESULT_W-1:0] m_data_o,
  output logic                m_timeout_o,
  output logic [TS_W-1:0]     m_ts_sec_o,
  output logic [TS_W-1:0]     m_ts_nsec_o
);

  localparam logic [5:0]  READ_BITS = (DATA_STATUS != 0) ? 6'd32 : 6'd24;
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic [NUM_CS-1:0]     mask_q, mask_d, rem;
  logic [NUM_CS-1:0]     csn_q, csn_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [RESULT_W-1:0]   data_q, data_d;
  logic                  timeout_q, timeout_d;
  logic [TS_W-1:0]       ts_sec_q, ts_sec_d;
  logic [TS_W-1:0]       ts_nsec_q, ts_nsec_d;
  logic                  zdone_q, zdone_d;

  logic                  sh_start, sh_busy, sh_done;
  logic [5:0]            sh_nbits;
  logic [RESULT_W-1:0]   sh_tx, sh_rx;

  assign rem = mask_q & ~(NUM_CS'(1) << idx_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    ts_sec_d  = ts_sec_q;
    ts_nsec_d = ts_nsec_q;
    zdone_d   = 1'b0;
    sh_start  = 1'b0;
    sh_nbits  = 6'd8;
    sh_tx     = {CMD_READ_DATA, {(RESULT_W-8){1'b1}}};
    unique case (state_q)
      ST_IDLE: begin
        if (measure_start_i) begin
          mask_d = ch_enable_i;
          if (ch_enable_i == '0) begin
            zdone_d = 1'b1;
          end else begin
            idx_d   = CW'(first_set(32'(ch_enable_i)));
            cnt_d   = '0;
            state_d = ST_CS_SETUP;
          end
        end
      end
      ST_CS_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_WAIT_RDY: begin
        // RDY wins over the terminal count when both land on the same cycle.
        if (!spi_miso_i && !sh_busy) begin
          ts_sec_d  = rtc_sec_i;
          ts_nsec_d = rtc_nsec_i;
          timeout_d = 1'b0;
          sh_start  = 1'b1;
          state_d   = ST_CMD;
        end else if (cnt_q == TO_LAST) begin
          ts_sec_d  = rtc_sec_i;
          ts_nsec_d = rtc_nsec_i;
          timeout_d = 1'b1;
          data_d    = '0;
          cnt_d     = '0;
          state_d   = ST_CS_HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CMD: begin
        if (sh_done) begin
          sh_start = 1'b1;
          sh_nbits = READ_BITS;
          sh_tx    = '1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (sh_done) begin
          // The ADC appends the status byte after the data; present it as the top byte.
          if (DATA_STATUS != 0) data_d = {sh_rx[STATUS_W-1:0], sh_rx[RESULT_W-1:STATUS_W]};
          else                  data_d = {{STATUS_W{1'b0}}, sh_rx[DATA_W-1:0]};
          cnt_d   = '0;
          state_d = ST_CS_HOLD;
        end
      end
      ST_CS_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = ST_OUTPUT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_OUTPUT: begin
        if (m_ready_i) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        mask_d = rem;
        if (rem == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = CW'(first_set(32'(rem)));
          cnt_d   = '0;
          state_d = ST_CS_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    csn_d = '1;
    if (state_d inside {ST_CS_SETUP, ST_WAIT_RDY, ST_CMD, ST_READ}) csn_d[idx_d] = 1'b0;
  end

  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mask_q    <= '0;
      csn_q     <= '1;
      cnt_q     <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
      ts_sec_q  <= '0;
      ts_nsec_q <= '0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      csn_q     <= csn_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      timeout_q <= timeout_d;
      ts_sec_q  <= ts_sec_d;
      ts_nsec_q <= ts_nsec_d;
      zdone_q   <= zdone_d;
    end
  end

  ad7124_spi_shift #(
    .CLK_DIV  (CLK_DIV),
    .MAX_BITS (RESULT_W)
  ) u_shift (
    .clk_i    (aclk_i),
    .rst_i    (areset_i),
    .start_i  (sh_start),
    .nbits_i  (sh_nbits),
    .tx_dat_i (sh_tx),
    .miso_i   (spi_miso_i),
    .busy_o   (sh_busy),
    .done_o   (sh_done),
    .rx_dat_o (sh_rx),
    .sclk_o   (spi_sclk_o),
    .mosi_o   (spi_mosi_o)
  );

  assign measure_ready_o = (state_q == ST_IDLE);
  assign measure_done_o  = (state_q == ST_DONE) | zdone_q;
  assign spi_csn_o       = csn_q;
  assign m_valid_o       = (state_q == ST_OUTPUT);
  assign m_chan_o        = idx_q;
  assign m_data_o        = data_q;
  assign m_timeout_o     = timeout_q;
  assign m_ts_sec_o      = ts_sec_q;
  assign m_ts_nsec_o     = ts_nsec_q;

endmodule

// File: tb/tb_ad7124_scan_seq.sv
// Directed bench for ad7124_scan_seq with a behavioural AD7124 bus model.
// The ADC returns data 0x345678 then status 0x12, so every good result reads 0x12345678.
module tb_ad7124_scan_seq;

  localparam int NCS  = 9;
  localparam int CDIV = 4;
  localparam int TO   = 100;
  localparam logic [31:0] EXP_DATA = 32'h1234_5678;
  localparam logic [31:0] SEC      = 32'h0001_2345;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            areset, measure_start, m_ready;
  logic            spi_miso = 1'b1;
  logic [NCS-1:0]  ch_enable;
  logic [31:0]     rtc_sec;
  logic [31:0]     rtc_nsec = '0;
  logic            measure_ready, measure_done, spi_sclk, spi_mosi, m_valid, m_timeout;
  logic [NCS-1:0]  spi_csn;
  logic [3:0]      m_chan;
  logic [31:0]     m_data, m_ts_sec, m_ts_nsec;

  ad7124_scan_seq #(
    .NUM_CS(NCS), .CLK_DIV(CDIV), .TIMEOUT_CYCLES(TO), .DATA_STATUS(1)
  ) dut (
    .aclk_i(clk), .areset_i(areset), .measure_start_i(measure_start),
    .measure_ready_o(measure_ready), .measure_done_o(measure_done),
    .ch_enable_i(ch_enable), .rtc_sec_i(rtc_sec), .rtc_nsec_i(rtc_nsec),
    .spi_sclk_o(spi_sclk), .spi_csn_o(spi_csn), .spi_mosi_o(spi_mosi), .spi_miso_i(spi_miso),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_chan_o(m_chan), .m_data_o(m_data),
    .m_timeout_o(m_timeout), .m_ts_sec_o(m_ts_sec), .m_ts_nsec_o(m_ts_nsec)
  );

  int total = 0;
  int bad   = 0;

  // ADC model and result monitor state
  logic [NCS-1:0] dead = '0;
  logic [NCS-1:0] prev_csn = '1;
  logic           prev_sclk = 1'b1;
  logic [7:0]     cmd_sh = '0;
  logic [31:0]    word = 32'h3456_7812;
  int cs_cnt = 0, fall_cnt = 0, sel = 0, nlow = 0;
  int cmd_cnt = 0, cmd_ok = 0, viol = 0, done_cnt = 0;
  int cs_len[NCS];
  int cs_lows[NCS];
  logic [31:0] rdy_ts[NCS];
  int          q_chan[$];
  logic [31:0] q_data[$];
  logic        q_to[$];
  logic [31:0] q_tsn[$];
  logic [31:0] q_tss[$];

  initial begin
    for (int c = 0; c < NCS; c++) begin
      cs_len[c] = 0; cs_lows[c] = 0; rdy_ts[c] = '0;
    end
  end

  always @(negedge clk) begin
    rtc_nsec = rtc_nsec + 32'd1;
    if (measure_done) done_cnt++;
    if (m_valid && m_ready) begin
      q_chan.push_back(int'(m_chan)); q_data.push_back(m_data); q_to.push_back(m_timeout);
      q_tsn.push_back(m_ts_nsec); q_tss.push_back(m_ts_sec);
    end
    nlow = 0; sel = 0;
    for (int c = 0; c < NCS; c++) begin
      if (!spi_csn[c]) begin nlow++; sel = c; end
      if (prev_csn[c] && !spi_csn[c]) cs_lows[c]++;
      if (!prev_csn[c] && spi_csn[c]) cs_len[c] = cs_cnt;
    end
    if (nlow > 1) viol++;
    if (spi_csn != prev_csn && !spi_sclk) viol++;
    if (nlow == 0) begin
      cs_cnt = 0; fall_cnt = 0; spi_miso = 1'b1;
    end else begin
      cs_cnt++;
      if (!dead[sel] && cs_cnt == 50 && fall_cnt == 0) begin
        spi_miso = 1'b0; rdy_ts[sel] = rtc_nsec;
      end
      if (prev_sclk && !spi_sclk) begin
        fall_cnt++;
        if (fall_cnt >= 9 && fall_cnt <= 40) spi_miso = word[40-fall_cnt];
      end
      if (!prev_sclk && spi_sclk && fall_cnt >= 1 && fall_cnt <= 8) begin
        cmd_sh = {cmd_sh[6:0], spi_mosi};
        if (fall_cnt == 8) begin
          cmd_cnt++;
          if (cmd_sh == 8'h42) cmd_ok++;
        end
      end
    end
    prev_sclk = spi_sclk;
    prev_csn  = spi_csn;
  end

  task automatic start_scan(input logic [NCS-1:0] mask);
    @(posedge clk); #1;
    ch_enable = mask; measure_start = 1'b1;
    @(posedge clk); #1;
    measure_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (spi_csn !== 9'h1FF) begin bad++; $display("FAIL reset_csn got=%h want=1ff", spi_csn); end
    total++; if (spi_sclk !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b want=1", spi_sclk); end
    total++; if (spi_mosi !== 1'b1) begin bad++; $display("FAIL reset_mosi got=%b want=1", spi_mosi); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    total++; if (measure_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", measure_done); end
    total++; if (measure_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", measure_ready); end
    total++; if ({m_data, m_ts_sec, m_ts_nsec, m_chan, m_timeout} !== '0) begin
      bad++; $display("FAIL reset_mdata got=%h/%h/%h/%h/%b want=all zero", m_data, m_ts_sec, m_ts_nsec, m_chan, m_timeout);
    end
    areset = 1'b0;
  endtask

  task automatic test_full_scan;
    int n0, d0, c0, k0, v0;
    n0 = q_chan.size(); d0 = done_cnt; c0 = cmd_cnt; k0 = cmd_ok; v0 = viol;
    start_scan(9'h1FF);
    wait_done(d0);
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_done got=%0d want=1", done_cnt - d0); end
    total++; if (q_chan.size() - n0 != 9) begin bad++; $display("FAIL full_count got=%0d want=9", q_chan.size() - n0); end
    for (int i = 0; i < 9; i++) begin
      if (n0 + i < q_chan.size()) begin
        total++; if (q_chan[n0+i] != i) begin bad++; $display("FAIL full_chan got=%0d want=%0d", q_chan[n0+i], i); end
        total++; if (q_data[n0+i] !== EXP_DATA) begin bad++; $display("FAIL full_data ch%0d got=%h want=%h", i, q_data[n0+i], EXP_DATA); end
        total++; if (q_to[n0+i] !== 1'b0) begin bad++; $display("FAIL full_timeout ch%0d got=%b want=0", i, q_to[n0+i]); end
        total++; if (q_tsn[n0+i] !== rdy_ts[i] || q_tss[n0+i] !== SEC) begin
          bad++; $display("FAIL full_ts ch%0d got=%h/%h want=%h/%h", i, q_tss[n0+i], q_tsn[n0+i], SEC, rdy_ts[i]);
        end
      end
    end
    total++; if (cmd_cnt - c0 != 9 || cmd_ok - k0 != 9) begin
      bad++; $display("FAIL full_cmd got=%0d bytes %0d ok want=9/9", cmd_cnt - c0, cmd_ok - k0);
    end
    total++; if (viol != v0) begin bad++; $display("FAIL full_csn_rules got=%0d violations want=0", viol - v0); end
  endtask

  task automatic test_sparse_mask;
    int n0, d0, l1, l8;
    int exp_ch[3];
    exp_ch[0] = 0; exp_ch[1] = 2; exp_ch[2] = 8;
    n0 = q_chan.size(); d0 = done_cnt; l1 = cs_lows[1]; l8 = cs_lows[8];
    start_scan(9'b100000101);
    wait_done(d0);
    total++; if (q_chan.size() - n0 != 3) begin bad++; $display("FAIL sparse_count got=%0d want=3", q_chan.size() - n0); end
    for (int i = 0; i < 3; i++) begin
      if (n0 + i < q_chan.size()) begin
        total++; if (q_chan[n0+i] != exp_ch[i] || q_data[n0+i] !== EXP_DATA) begin
          bad++; $display("FAIL sparse_result got=ch%0d/%h want=ch%0d/%h", q_chan[n0+i], q_data[n0+i], exp_ch[i], EXP_DATA);
        end
      end
    end
    total++; if (cs_lows[1] != l1) begin bad++; $display("FAIL sparse_csn1 got=%0d lows want=0", cs_lows[1] - l1); end
    total++; if (cs_lows[8] - l8 != 1) begin bad++; $display("FAIL sparse_csn8 got=%0d lows want=1", cs_lows[8] - l8); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL sparse_done got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int n0, d0;
    n0 = q_chan.size(); d0 = done_cnt;
    dead = 9'h008;
    start_scan(9'h018);
    wait_done(d0);
    dead = '0;
    total++; if (q_chan.size() - n0 != 2) begin bad++; $display("FAIL to_count got=%0d want=2", q_chan.size() - n0); end
    if (q_chan.size() - n0 >= 2) begin
      total++; if (q_chan[n0] != 3 || q_to[n0] !== 1'b1 || q_data[n0] !== 32'h0) begin
        bad++; $display("FAIL to_ch3 got=ch%0d to=%b data=%h want=ch3 to=1 data=0", q_chan[n0], q_to[n0], q_data[n0]);
      end
      total++; if (q_chan[n0+1] != 4 || q_to[n0+1] !== 1'b0 || q_data[n0+1] !== EXP_DATA) begin
        bad++; $display("FAIL to_ch4 got=ch%0d to=%b data=%h want=ch4 to=0 data=%h", q_chan[n0+1], q_to[n0+1], q_data[n0+1], EXP_DATA);
      end
    end
    total++; if (cs_len[3] != TO + CDIV) begin bad++; $display("FAIL to_csn_len got=%0d want=%0d", cs_len[3], TO + CDIV); end
  endtask

  task automatic test_backpressure;
    int n0, d0;
    logic [45:0] want, got;
    n0 = q_chan.size(); d0 = done_cnt;
    m_ready = 1'b0;
    start_scan(9'h003);
    for (int i = 0; i < 5000 && !m_valid; i++) begin @(posedge clk); #1; end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid got=%b want=1", m_valid); end
    want = {1'b1, 4'd0, 9'h1FF, EXP_DATA};
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      got = {m_valid, m_chan, spi_csn, m_data};
      total++; if (got !== want) begin bad++; $display("FAIL bp_hold cyc%0d got=%h want=%h", i, got, want); end
    end
    m_ready = 1'b1;
    wait_done(d0);
    total++; if (q_chan.size() - n0 != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", q_chan.size() - n0); end
    if (q_chan.size() - n0 >= 2) begin
      total++; if (q_chan[n0] != 0 || q_chan[n0+1] != 1 || q_data[n0+1] !== EXP_DATA) begin
        bad++; $display("FAIL bp_order got=ch%0d,ch%0d/%h want=ch0,ch1/%h", q_chan[n0], q_chan[n0+1], q_data[n0+1], EXP_DATA);
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int n0, d0;
    d0 = done_cnt;
    start_scan(9'h001);
    for (int i = 0; i < 3000 && fall_cnt < 20; i++) begin @(posedge clk); #1; end
    total++; if (fall_cnt < 20) begin bad++; $display("FAIL rst_reach_read got=%0d falls want>=20", fall_cnt); end
    areset = 1'b1;
    @(posedge clk); #1;
    total++; if ({spi_csn, spi_sclk, m_valid, measure_ready} !== {9'h1FF, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rst_mid got=csn%h sclk%b vld%b rdy%b want=csn1ff sclk1 vld0 rdy1", spi_csn, spi_sclk, m_valid, measure_ready);
    end
    total++; if (m_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data got=%h want=0", m_data); end
    areset = 1'b0;
    total++; if (done_cnt != d0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", done_cnt - d0); end
    n0 = q_chan.size();
    start_scan(9'h004);
    wait_done(d0);
    total++; if (q_chan.size() - n0 != 1) begin bad++; $display("FAIL rst_after_count got=%0d want=1", q_chan.size() - n0); end
    if (q_chan.size() - n0 >= 1) begin
      total++; if (q_chan[n0] != 2 || q_data[n0] !== EXP_DATA) begin
        bad++; $display("FAIL rst_after_result got=ch%0d/%h want=ch2/%h", q_chan[n0], q_data[n0], EXP_DATA);
      end
    end
  endtask

  task automatic test_mask_zero_busy;
    int n0, d0;
    d0 = done_cnt;
    start_scan('0);
    total++; if (measure_done !== 1'b1 || measure_ready !== 1'b1) begin
      bad++; $display("FAIL zero_done got=done%b rdy%b want=done1 rdy1", measure_done, measure_ready);
    end
    @(posedge clk); #1;
    total++; if (measure_done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", measure_done); end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", done_cnt - d0); end
    n0 = q_chan.size(); d0 = done_cnt;
    start_scan(9'h001);
    repeat (20) @(posedge clk);
    #1;
    total++; if (measure_ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", measure_ready); end
    ch_enable = 9'h1FF; measure_start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    measure_start = 1'b0;
    wait_done(d0);
    repeat (500) @(posedge clk);
    #1;
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", done_cnt - d0); end
    total++; if (q_chan.size() - n0 != 1) begin bad++; $display("FAIL busy_count got=%0d want=1", q_chan.size() - n0); end
    if (q_chan.size() - n0 >= 1) begin
      total++; if (q_chan[n0] != 0) begin bad++; $display("FAIL busy_chan got=%0d want=0", q_chan[n0]); end
    end
  endtask

  initial begin
    areset = 1'b1; measure_start = 1'b0; ch_enable = '0; m_ready = 1'b1; rtc_sec = SEC;
    test_reset;
    test_full_scan;
    test_sparse_mask;
    test_timeout;
    test_backpressure;
    test_reset_mid_read;
    test_mask_zero_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ad7124_scan_seq.md
Name: ad7124_scan_seq

Overview:
- Per-board AD7124 scan sequencer for the next-generation acquisition IP.
- Drives one shared SPI bus with NUM_CS chip selects (TC ADCs plus RTD ADC).
- On each measure_start it walks the enabled chip selects: waits for DOUT/RDY, reads the data register and timestamps each sample.
- Each result goes out on a valid/ready stream. One instance per board; outputs feed the AXI-side result FIFO.

Parameters:
- NUM_CS, 9, number of chip selects/ADCs on the bus (1..32).
- CLK_DIV, 4, aclk cycles per SCLK half-period (>=2).
- TIMEOUT_CYCLES, 2000000, maximum aclk cycles spent waiting for RDY per channel.
- DATA_STATUS, 1, 1 = read 32 bits (24-bit data + status byte); 0 = read 24 bits.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- measure_start  in  1  start a scan (pulse or level)
- measure_ready  out  1  high when idle and able to accept a start
- measure_done  out  1  one-cycle pulse when the scan completes
- ch_enable  in  NUM_CS  channel mask, sampled on start
- rtc_sec  in  32  RTC seconds
- rtc_nsec  in  32  RTC nanoseconds
- spi_sclk  out  1  SPI clock, mode 3, idles high
- spi_csn  out  NUM_CS  active-low chip selects
- spi_mosi  out  1  serial data to the ADC
- spi_miso  in  1  ADC DOUT/RDY, already registered in the IOB
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_chan  out  $clog2(NUM_CS) (min 1)  channel index
- m_data  out  32  {status,data24} or {8'h00,data24}
- m_timeout  out  1  RDY was never seen; m_data forced to 0
- m_ts_sec  out  32  RTC seconds captured at RDY
- m_ts_nsec  out  32  RTC nanoseconds captured at RDY

Behaviour:
- Reset values: spi_csn all 1, spi_sclk 1, spi_mosi 1, m_valid 0, measure_done 0, measure_ready 1, m_* data 0, state IDLE. Reset mid-transfer aborts immediately with the same values.
- measure_ready = (state==IDLE). A start is accepted when measure_start & measure_ready. At acceptance, ch_enable is latched and idx is set to the lowest enabled channel.
- A start while busy is ignored.
- A start with mask 0: measure_done pulses on the next cycle; state stays IDLE.
- SCLK timing: period is 2*CLK_DIV aclk cycles.
  - MOSI changes on the falling edge.
  - MISO is sampled on the last aclk of the high half-period.
  - Data is MSB first.
- FSM states:
  - IDLE
  - CS_SETUP: csn[idx]=0; hold CLK_DIV cycles.
  - WAIT_RDY: spi_miso==0 → capture rtc_sec/rtc_nsec, go to CMD. Counter reaches TIMEOUT_CYCLES → m_timeout=1, m_data=0, go to CS_HOLD.
  - CMD: shift 8'h42 (read DATA register) over 8 SCLKs.
  - READ: shift 24 bits, or 32 bits when DATA_STATUS=1.
  - CS_HOLD: csn high; hold CLK_DIV cycles.
  - OUTPUT: m_valid=1, with m_* stable until m_ready.
  - NEXT: advance idx to the next enabled channel. None left → DONE.
  - DONE: measure_done=1 for one cycle, then IDLE.
- Only one CSN bit is low at a time. CSN never changes while SCLK is low.
- m_valid & m_ready in the same cycle it is raised → accepted that cycle, advance next cycle.
- A channel whose RDY is already low at CS assertion is detected on the first WAIT_RDY cycle.
- TIMEOUT counter restarts at 0 for each channel. RDY arriving on the same cycle as the terminal count counts as RDY, not timeout.

Decomposition:
- Package ad7124_pkg holds:
  - CMD_READ_DATA = 8'h42
  - REG_STATUS = 6'h00
  - the FSM state enum
  - the result field-width localparams
- One sub-module, ad7124_spi_shift: a generic N-bit mode-3 shifter with start/busy/done and a CLK_DIV-based SCLK generator. Instantiate it once and reuse it for CMD and READ.

Test Plan:
- NUM_CS=9, mask 9'h1FF, ADC model drives RDY low 50 cycles after CS and returns 0x12345678 → 9 results in order chan 0..8, each m_data=32'h12345678, m_timeout=0, MOSI byte 0x42 each time, one measure_done pulse.
- Mask 9'b100000101 → results only for chan 0, 2, 8; csn[1] never goes low.
- Model never asserts RDY on chan 3, TIMEOUT_CYCLES=100 → chan 3 result has m_timeout=1, m_data=0, and csn[3] low for exactly 100+CLK_DIV cycles; the scan continues to chan 4.
- m_ready held low 200 cycles on the first result → m_valid and m_data stable throughout, spi_csn all 1, no second transfer starts.
- areset pulsed mid-READ → next cycle spi_csn=all 1, spi_sclk=1, m_valid=0, measure_ready=1; a new start then works normally.
- Mask 0, and a second measure_start while busy → mask 0 yields measure_done one cycle after start; the start while busy is ignored (single done pulse).
